// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the multi-cycle multiply/divide sequencer:
//   - state_e      : sequencer state encoding
//   - ITER_COUNT   : number of Booth / restoring-division iterations
//   - MUL_LATENCY  : edges from accepted start to the last multiply iteration
//   - DIV_LATENCY  : edges from accepted start to the divide FIX step
// ---------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NEG_A = 3'd1,
        S_NEG_B = 3'd2,
        S_ITER  = 3'd3,
        S_FIX   = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    localparam int ITER_COUNT  = 32;
    localparam int MUL_LATENCY = 32;
    localparam int DIV_LATENCY = 35;

endpackage

// File: rtl/CSA_32bit.sv
// ---------------------------------------------------------------------------
// CSA_32bit
// 32-bit carry-select adder built from four 8-bit blocks. Each block
// precomputes its sum for carry-in 0 and 1; the incoming carry picks one.
// Ports:
//   a, b        in  32 : addends
//   cin         in  1  : carry in
//   sum         out 32 : a + b + cin (low 32 bits)
//   cout        out 1  : carry out of bit 31
//   overflow    out 1  : signed overflow of the addition
//   isLessThan  out 1  : signed a < b when driven as a + ~b + 1
//   isNotEqual  out 1  : a != b when driven as a + ~b + 1
// ---------------------------------------------------------------------------
module CSA_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout,
    output logic        overflow,
    output logic        isLessThan,
    output logic        isNotEqual
);

    localparam int BLK  = 8;
    localparam int NBLK = 4;

    logic [NBLK:0] carry_s;
    logic          c31_s;

    assign carry_s[0] = cin;

    for (genvar g = 0; g < NBLK; g++) begin : g_blk
        logic [BLK:0] sum0_s;
        logic [BLK:0] sum1_s;

        assign sum0_s = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
        assign sum1_s = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]}
                        + {{BLK{1'b0}}, 1'b1};
        assign sum[g*BLK +: BLK] = carry_s[g] ? sum1_s[BLK-1:0] : sum0_s[BLK-1:0];
        assign carry_s[g+1]      = carry_s[g] ? sum1_s[BLK]     : sum0_s[BLK];
    end

    // Carry into the MSB recovered from the MSB sum bit; overflow when it
    // differs from the carry out.
    assign c31_s      = a[31] ^ b[31] ^ sum[31];
    assign cout       = carry_s[NBLK];
    assign overflow   = c31_s ^ cout;
    assign isLessThan = sum[31] ^ overflow;
    assign isNotEqual = |sum;

endmodule

// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq
// Multi-cycle signed multiply (radix-2 Booth, low 32 bits) / signed
// truncating divide (restoring division on magnitudes). All add, subtract
// and negate operations share one CSA_32bit instance.
// Ports:
//   clock         in  1  : clock, rising edge
//   reset_n       in  1  : asynchronous active-low reset
//   start         in  1  : request, sampled only in IDLE
//   op_div        in  1  : 0 = multiply, 1 = divide (sampled with start)
//   operand_a     in  32 : multiplicand / dividend
//   operand_b     in  32 : multiplier / divisor
//   busy          out 1  : high in every state except IDLE
//   result_ready  out 1  : one-cycle pulse in DONE
//   result        out 32 : product low word or quotient, held
//   exception     out 1  : overflow or divide-by-zero, held with result
// ---------------------------------------------------------------------------
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        op_div,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        busy,
    output logic        result_ready,
    output logic [31:0] result,
    output logic        exception
);

    localparam logic [4:0] LAST_CNT = 5'(ITER_COUNT - 1);

    state_e      state_q,  state_d;
    logic [4:0]  cnt_q,    cnt_d;
    logic [31:0] acc_q,    acc_d;     // Booth A / division remainder R
    logic [31:0] q_q,      q_d;       // Booth Q / dividend-quotient
    logic        q1_q,     q1_d;      // Booth q_-1
    logic [31:0] m_q,      m_d;       // multiplicand M / divisor magnitude
    logic        div_q,    div_d;
    logic        neg_q,    neg_d;     // quotient sign: sign(a) ^ sign(b)
    logic [31:0] result_q, result_d;
    logic        exc_q,    exc_d;
    logic        busy_q,   ready_q;

    logic [31:0] add_a_s, add_b_s, add_sum_s;
    logic        add_cin_s, add_cout_s, add_ovf_s;
    logic        csa_lt_unused_s, csa_ne_unused_s;
    logic [31:0] rem_sh_s;
    logic        booth_sign_s;

    CSA_32bit u_csa (
        .a          (add_a_s),
        .b          (add_b_s),
        .cin        (add_cin_s),
        .sum        (add_sum_s),
        .cout       (add_cout_s),
        .overflow   (add_ovf_s),
        .isLessThan (csa_lt_unused_s),
        .isNotEqual (csa_ne_unused_s)
    );

    // Remainder shifted left with the next dividend bit.
    assign rem_sh_s = {acc_q[30:0], q_q[31]};
    // True sign of the Booth partial sum, immune to overflow.
    assign booth_sign_s = add_sum_s[31] ^ add_ovf_s;

    // Shared adder operand and carry-in select, driven by state.
    always_comb begin
        add_a_s   = 32'd0;
        add_b_s   = 32'd0;
        add_cin_s = 1'b0;
        case (state_q)
            S_NEG_A: begin
                add_b_s   = q_q[31] ? ~q_q : q_q;
                add_cin_s = q_q[31];
            end
            S_NEG_B: begin
                add_b_s   = m_q[31] ? ~m_q : m_q;
                add_cin_s = m_q[31];
            end
            S_ITER: begin
                if (div_q) begin
                    add_a_s   = rem_sh_s;
                    add_b_s   = ~m_q;
                    add_cin_s = 1'b1;
                end else begin
                    add_a_s = acc_q;
                    case ({q_q[0], q1_q})
                        2'b01: begin
                            add_b_s   = m_q;
                            add_cin_s = 1'b0;
                        end
                        2'b10: begin
                            add_b_s   = ~m_q;
                            add_cin_s = 1'b1;
                        end
                        default: begin
                            add_b_s   = 32'd0;
                            add_cin_s = 1'b0;
                        end
                    endcase
                end
            end
            S_FIX: begin
                add_b_s   = neg_q ? ~q_q : q_q;
                add_cin_s = neg_q;
            end
            default: begin
                add_a_s   = 32'd0;
                add_b_s   = 32'd0;
                add_cin_s = 1'b0;
            end
        endcase
    end

    // Next-state, datapath update and result capture on entry to DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        q_d      = q_q;
        q1_d     = q1_q;
        m_d      = m_q;
        div_d    = div_q;
        neg_d    = neg_q;
        result_d = result_q;
        exc_d    = exc_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    div_d = op_div;
                    acc_d = 32'd0;
                    q_d   = operand_a;
                    q1_d  = 1'b0;
                    m_d   = operand_b;
                    cnt_d = 5'd0;
                    if (!op_div) begin
                        state_d = S_ITER;
                    end else if (operand_b == 32'd0) begin
                        state_d  = S_DONE;
                        result_d = 32'd0;
                        exc_d    = 1'b1;
                    end else begin
                        state_d = S_NEG_A;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_NEG_A: begin
                q_d     = add_sum_s;
                neg_d   = q_q[31];
                state_d = S_NEG_B;
            end
            S_NEG_B: begin
                m_d     = add_sum_s;
                neg_d   = neg_q ^ m_q[31];
                state_d = S_ITER;
            end
            S_ITER: begin
                if (div_q) begin
                    // cout = 1 means no borrow: the divisor fits.
                    if (add_cout_s) begin
                        acc_d = add_sum_s;
                        q_d   = {q_q[30:0], 1'b1};
                    end else begin
                        acc_d = rem_sh_s;
                        q_d   = {q_q[30:0], 1'b0};
                    end
                end else begin
                    acc_d = {booth_sign_s, add_sum_s[31:1]};
                    q_d   = {add_sum_s[0], q_q[31:1]};
                    q1_d  = q_q[0];
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q != LAST_CNT) begin
                    state_d = S_ITER;
                end else if (div_q) begin
                    state_d = S_FIX;
                end else begin
                    state_d  = S_DONE;
                    result_d = q_d;
                    // High word must be the sign extension of the low word.
                    exc_d    = (acc_d != {32{q_d[31]}});
                end
            end
            S_FIX: begin
                result_d = add_sum_s;
                // Only 0x8000_0000 / -1 yields a positive quotient with MSB set.
                exc_d    = ~neg_q & q_q[31];
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            acc_q    <= 32'd0;
            q_q      <= 32'd0;
            q1_q     <= 1'b0;
            m_q      <= 32'd0;
            div_q    <= 1'b0;
            neg_q    <= 1'b0;
            result_q <= 32'd0;
            exc_q    <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            q1_q     <= q1_d;
            m_q      <= m_d;
            div_q    <= div_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            busy_q   <= (state_d != S_IDLE);
            ready_q  <= (state_d == S_DONE);
        end
    end

    assign busy         = busy_q;
    assign result_ready = ready_q;
    assign result       = result_q;
    assign exception    = exc_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_muldiv_seq
// Directed self-checking bench for muldiv_seq with hand-computed results.
// ---------------------------------------------------------------------------
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        op_div;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        result_ready;
    logic [31:0] result;
    logic        exception;

    int total = 0;
    int bad   = 0;
    int lat;
    bit busy_ok;

    muldiv_seq dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .op_div       (op_div),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .busy         (busy),
        .result_ready (result_ready),
        .result       (result),
        .exception    (exception)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a start pulse from the current (negedge-aligned) time through E0.
    task automatic launch(input logic op, input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        op_div    = op;
        operand_a = a;
        operand_b = b;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // Count edges after the last sampled edge until result_ready is seen.
    task automatic wait_done(output int n, output bit bok);
        n   = 0;
        bok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (result_ready) break;
            if (!busy) bok = 1'b0;
            n++;
        end
    endtask

    task automatic run(input string tag, input logic op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input logic exp_exc, input int exp_lat);
        int  n;
        bit  bok;
        @(negedge clock);
        launch(op, a, b);
        wait_done(n, bok);
        chk({tag, ".lat"},   32'(n),         32'(exp_lat));
        chk({tag, ".busyw"}, 32'(bok),       32'd1);
        chk({tag, ".busyd"}, 32'(busy),      32'd1);
        chk({tag, ".res"},   result,         exp_res);
        chk({tag, ".exc"},   32'(exception), 32'(exp_exc));
        @(negedge clock);
        chk({tag, ".rdy0"},  32'(result_ready), 32'd0);
        chk({tag, ".idle"},  32'(busy),         32'd0);
        chk({tag, ".hold"},  result,            exp_res);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        op_div    = 1'b0;
        operand_a = 32'd0;
        operand_b = 32'd0;
        #12;
        chk("rst.busy", 32'(busy),         32'd0);
        chk("rst.rdy",  32'(result_ready), 32'd0);
        chk("rst.res",  result,            32'd0);
        chk("rst.exc",  32'(exception),    32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        run("mul7x-3",  1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, MUL_LATENCY);
        run("mul2^16sq", 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, MUL_LATENCY);
        run("mulmin",   1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, MUL_LATENCY);
        run("mul-5x-6", 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_001E, 1'b0, MUL_LATENCY);
        run("mulmaxmin", 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b1, MUL_LATENCY);
        run("div-7/2",  1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, DIV_LATENCY);
        run("div100/-7", 1'b1, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, DIV_LATENCY);
        run("div5/0",   1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b1, 0);
        run("divmin/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, DIV_LATENCY);
        run("divmax/min", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, DIV_LATENCY);
        run("div-100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 1'b0, DIV_LATENCY);

        // Start held through DONE is ignored; accepted once back in IDLE.
        @(negedge clock);
        launch(1'b0, 32'h0000_0002, 32'h0000_0004);
        wait_done(lat, busy_ok);
        chk("b2b.first", result, 32'h0000_0008);
        start     = 1'b1;
        op_div    = 1'b0;
        operand_a = 32'h0000_0003;
        operand_b = 32'h0000_0003;
        @(negedge clock);
        chk("done.ign", 32'(busy), 32'd0);
        @(posedge clock);
        #1 start = 1'b0;
        wait_done(lat, busy_ok);
        chk("b2b.lat", 32'(lat), 32'(MUL_LATENCY));
        chk("b2b.res", result,   32'h0000_0009);

        // Stray start during ITER must not disturb the running multiply.
        @(negedge clock);
        launch(1'b0, 32'h0000_0007, 32'hFFFF_FFFD);
        repeat (10) @(negedge clock);
        start     = 1'b1;
        op_div    = 1'b1;
        operand_a = 32'h0000_0005;
        operand_b = 32'h0000_0000;
        @(posedge clock);
        #1 start = 1'b0;
        wait_done(lat, busy_ok);
        chk("stray.lat",  32'(lat),       32'd22);
        chk("stray.busy", 32'(busy_ok),   32'd1);
        chk("stray.res",  result,         32'hFFFF_FFEB);
        chk("stray.exc",  32'(exception), 32'd0);

        // Asynchronous reset mid-ITER clears outputs without a clock edge.
        @(negedge clock);
        launch(1'b0, 32'h0000_0003, 32'h0000_0005);
        repeat (5) @(negedge clock);
        chk("mid.busy", 32'(busy), 32'd1);
        chk("mid.hold", result,    32'hFFFF_FFEB);
        #2 reset_n = 1'b0;
        #1;
        chk("arst.busy", 32'(busy),         32'd0);
        chk("arst.rdy",  32'(result_ready), 32'd0);
        chk("arst.res",  result,            32'd0);
        chk("arst.exc",  32'(exception),    32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        run("post.mul", 1'b0, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 1'b0, MUL_LATENCY);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
